// File: rtl/mc_pkg.sv
// mc_pkg: state, ALU, mux-select and cmd encodings for the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4 = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA = 2'b01;
  localparam logic [1:0] RES_ALU = 2'b10;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: maps Funct and CondEx to ALU op, flag writes, NoWrite and illegal cmd (ADD, quiet when alu_op=0)
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic       alu_op,
  input  logic [5:0] funct,
  input  logic       cond_ex,
  output logic [2:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write,
  output logic       illegal_cmd
);
  logic arith;
  always_comb begin
    alu_control = ALU_ADD;
    arith = 1'b0;
    no_write = 1'b0;
    illegal_cmd = 1'b0;
    if (alu_op)
      case (funct[4:1])
        CMD_ADD: arith = 1'b1;
        CMD_SUB: begin alu_control = ALU_SUB; arith = 1'b1; end
        CMD_AND: alu_control = ALU_AND;
        CMD_ORR: alu_control = ALU_ORR;
        CMD_EOR: alu_control = ALU_EOR;
        CMD_CMP: begin alu_control = ALU_SUB; arith = 1'b1; no_write = 1'b1; end
        default: illegal_cmd = 1'b1;
      endcase
    flag_w = {2{alu_op & funct[0] & cond_ex}} & {1'b1, arith};
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: per-instruction sequencing FSM driving datapath muxes/enables and a ready-handshaked memory port
module multicycle_controller
  import mc_pkg::*;
#(
  parameter logic [3:0] PC_REG = 4'd15,
  parameter int unsigned FETCH_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       mem_req,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_err
);
  state_t state, next;
  logic [31:0] cnt;
  logic alu_op, no_write, illegal_cmd, nowrite_q, timeout_hit, rw, pcs;
  assign alu_op = (state == EXECR || state == EXECI) && !reset;
  assign timeout_hit = FETCH_TIMEOUT != 0 && state == FETCH && !mem_ready && cnt + 32'd1 == FETCH_TIMEOUT;
  mc_alu_decode u_dec (
    .alu_op(alu_op),
    .funct(Funct),
    .cond_ex(CondEx),
    .alu_control(ALUControl),
    .flag_w(FlagW),
    .no_write(no_write),
    .illegal_cmd(illegal_cmd)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= FETCH;
      cnt <= '0;
      nowrite_q <= 1'b0;
    end else begin
      state <= next;
      cnt <= (state != FETCH || mem_ready || timeout_hit) ? '0 : cnt + 32'd1;
      if (alu_op) nowrite_q <= no_write | illegal_cmd;
    end
  always_comb begin
    next = state;
    IRWrite = 1'b0;
    AdrSrc = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    PCWrite = 1'b0;
    MemWrite = 1'b0;
    mem_req = 1'b0;
    instr_done = 1'b0;
    illegal = 1'b0;
    mem_err = 1'b0;
    rw = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_4;
        ResultSrc = RES_ALU;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        mem_err = timeout_hit;
        next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_4;
        ResultSrc = RES_ALU;
        illegal = Op == 2'b11;
        next = Op == 2'b01 ? MEMADR : Op == 2'b10 ? BRANCH : Op == 2'b11 ? FETCH : Funct[5] ? EXECI : EXECR;
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        next = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        AdrSrc = 1'b1;
        next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWR: begin
        mem_req = CondEx;
        AdrSrc = 1'b1;
        MemWrite = CondEx;
        instr_done = mem_ready | ~CondEx;
        next = instr_done ? FETCH : MEMWR;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        rw = CondEx;
        instr_done = 1'b1;
        next = FETCH;
      end
      EXECR: begin
        illegal = illegal_cmd;
        next = ALUWB;
      end
      EXECI: begin
        ALUSrcB = SRCB_IMM;
        illegal = illegal_cmd;
        next = ALUWB;
      end
      ALUWB: begin
        rw = CondEx & ~nowrite_q;
        instr_done = 1'b1;
        next = FETCH;
      end
      BRANCH: begin
        ALUSrcB = SRCB_IMM;
        ResultSrc = RES_ALU;
        PCWrite = CondEx;
        instr_done = 1'b1;
        next = FETCH;
      end
      default: next = FETCH;
    endcase
    pcs = rw && Rd == PC_REG;
    RegWrite = rw & ~pcs;
    PCWrite = PCWrite | pcs;
    ImmSrc = Op;
    RegSrc = {Op == 2'b01, Op == 2'b10};
    if (reset)
      {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, PCWrite, RegWrite, MemWrite, mem_req, instr_done, illegal, mem_err} = '0;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle ARM-subset core. Drives the shared ALU, register file, instruction register and a single unified memory port over several cycles per instruction.
- Decodes Op, Funct and Rd in DECODE and steps through fetch, execute, memory and writeback states.
- Handles variable-latency memory with a ready handshake.
- Sits between the instruction register and the condition-check logic on one side and the datapath muxes and enables on the other.

Parameters:
- PC_REG, 15, register index whose write redirects the PC (PCS path).
- FETCH_TIMEOUT, 0, if nonzero, the cycle count waiting on mem_ready after which mem_err pulses. 0 disables the timeout.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- Op  in  2  instruction class from instruction register
- Funct  in  6  instruction Funct field (I, cmd[3:0], S/L)
- Rd  in  4  destination register
- CondEx  in  1  registered condition-pass from condition logic; valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- IRWrite  out  1  latch instruction
- AdrSrc  out  1  0 = PC, 1 = ALU result onto memory address
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 = reg B, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU direct
- ImmSrc  out  2  immediate extend select (= Op)
- RegSrc  out  2  [0] = Op==10, [1] = Op==01
- ALUControl  out  3  ALU operation
- FlagW  out  2  [1] NZ write, [0] CV write, gated by CondEx
- PCWrite  out  1  PC enable
- RegWrite  out  1  register file write
- MemWrite  out  1  memory write strobe
- mem_req  out  1  memory access request
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse on undecodable instruction
- mem_err  out  1  one-cycle pulse on fetch timeout

Behaviour:
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- **Reset:** while reset is high, state <= FETCH and all outputs are forced to 0. Reset mid-instruction discards the instruction; no write is committed in that cycle.
- **Output decode:** all outputs are combinational from state and inputs. There is no added latency.
- **FETCH:** mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - IRWrite and PCWrite are asserted only when mem_ready=1; the FSM then goes to DECODE.
  - Otherwise it holds in FETCH with no side effects.
- **DECODE:** ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD (reads PC+8). Next state:
  - Op=01 -> MEMADR
  - Op=00, Funct[5]=0 -> EXECR
  - Op=00, Funct[5]=1 -> EXECI
  - Op=10 -> BRANCH
  - Op=11 -> FETCH with illegal pulse
- **MEMADR:** ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 -> MEMRD, else -> MEMWR.
- **MEMRD:** mem_req=1, AdrSrc=1. Holds until mem_ready, then -> MEMWB.
- **MEMWR:** mem_req=1, AdrSrc=1, MemWrite=CondEx. Holds until mem_ready, then -> FETCH with instr_done.
  - If CondEx=0, mem_req=0 and the FSM goes to FETCH immediately.
- **MEMWB:** ResultSrc=01, RegWrite=CondEx -> FETCH with instr_done.
- **EXECR / EXECI:** ALUSrcA=0, ALUSrcB=00 / 01. ALUControl and FlagW come from the ALU decode. Next state is ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=CondEx & ~NoWrite -> FETCH with instr_done.
- **BRANCH:** ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=CondEx -> FETCH with instr_done.
- **PCS:** in MEMWB or ALUWB, if Rd==PC_REG and the write is enabled, PCWrite=1 and RegWrite=0.
- **ALU decode (cmd = Funct[4:1]):**
  - 0100 ADD
  - 0010 SUB
  - 0000 AND
  - 1100 ORR
  - 0001 EOR
  - 1010 CMP (SUB, NoWrite=1)
  - Any other cmd: ADD, RegWrite suppressed, illegal pulse in EXEC state.
  - FlagW[1] = Funct[0] & CondEx.
  - FlagW[0] = Funct[0] & CondEx & (cmd is ADD, SUB or CMP).
  - In non-EXEC states: FlagW=0, NoWrite=0.
- **Timeout:** a counter increments each cycle in FETCH while mem_ready=0 and clears on leaving FETCH. When it reaches FETCH_TIMEOUT, mem_err pulses once and the counter clears; the FSM stays in FETCH.
- **Simultaneous events:** reset has priority over mem_ready. mem_ready outside FETCH, MEMRD and MEMWR is ignored.

Decomposition:
- Package mc_pkg:
  - state enum
  - ALUControl encodings: ADD=000, SUB=001, AND=010, ORR=011, EOR=100
  - ALUSrcB and ResultSrc localparams
  - cmd codes
- Sub-module mc_alu_decode: combinational map from alu_op, Funct and CondEx to ALUControl, FlagW, NoWrite and illegal_cmd.

Test Plan:
1. **Reset then fetch:** reset=1 for 2 cycles -> all outputs 0. After release with mem_ready=1 -> FETCH shows IRWrite=1, PCWrite=1, then DECODE.
2. **Fetch wait:** mem_ready=0 for 3 cycles -> stays in FETCH with IRWrite=0 and PCWrite=0. Then mem_ready=1 -> IRWrite pulse and move to DECODE.
3. **ADDS R1:** Op=00, Funct=101001, CondEx=1 -> EXECI shows ALUControl=000, FlagW=11; ALUWB shows RegWrite=1; instr_done pulses on cycle 4.
4. **CMP:** Funct=010101 -> ALUControl=001, NoWrite=1, FlagW=11; RegWrite=0 in ALUWB.
5. **LDR, 2-cycle memory wait:** Op=01, Funct[0]=1 -> MEMRD holds 2 cycles with AdrSrc=1; MEMWB shows ResultSrc=01, RegWrite=1. With Rd=15 instead -> PCWrite=1, RegWrite=0.
6. **Failed-condition branch and STR:** CondEx=0 -> PCWrite=0 and MemWrite=0, both return to FETCH. Op=11 -> illegal pulse in DECODE.
